// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared state encoding and constants for the 7-segment scan
//             controller (slot phases, dark nibble code, inactive levels).
//  Revision : 1.0  initial release
// ============================================================================
package display_pkg;

    // Phases of one digit slot: guard blanking, encoder setup, visible show
    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Nibble code the downstream encoder renders as all segments dark
    localparam logic [3:0] c_BLANK_NIBBLE = 4'hF;
    // Anode enables and decimal point are active-low
    localparam logic       c_ANODE_OFF    = 1'b1;
    localparam logic       c_DP_OFF       = 1'b1;

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Per-slot prescaler. Counts 0..REFRESH_DIV-1 and flags the last
//             blanking cycle, the cycle before slot end, and the slot end.
//  Revision : 1.0  initial release
// ============================================================================
module scan_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    output logic blank_end,
    output logic pre_slot_end,
    output logic slot_end
);

    localparam int                 c_CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_PRE   = c_CNT_W'(REFRESH_DIV - 2);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(REFRESH_DIV - 1);

    logic [c_CNT_W-1:0] r_slot_cnt;

    // Free-running slot counter, restarts at zero on every slot boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt <= '0;
        end else if (r_slot_cnt == c_SLOT_LAST) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    assign blank_end    = (r_slot_cnt == c_BLANK_LAST);
    assign pre_slot_end = (r_slot_cnt == c_SLOT_PRE);
    assign slot_end     = (r_slot_cnt == c_SLOT_LAST);

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_ctrl
//  Purpose  : Time-multiplexes N_DIGITS BCD nibbles onto one shared nibble
//             encoder and segment bus, with a blanking guard between digits,
//             optional leading-zero suppression and frame-aligned value latch.
//  Revision : 1.0  initial release
// ============================================================================
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    output logic [3:0]            nibble_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   digit_sel_n,
    output logic                  frame_done
);

    localparam int                 c_IDX_W    = $clog2(N_DIGITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_DIGITS - 1);

    scan_state_t          r_state, w_state_next;
    logic [c_IDX_W-1:0]   r_idx, w_idx_next;
    logic                 w_blank_end, w_pre_slot_end, w_slot_end, w_wrap;

    logic [4*N_DIGITS-1:0] r_shadow_val, r_pend_val;
    logic [N_DIGITS-1:0]   r_shadow_dp, r_shadow_blank, r_pend_dp, r_pend_blank;
    logic                  r_pending;
    logic [N_DIGITS-1:0]   w_lz, w_dark;

    logic [3:0]            r_nibble, w_nibble_next;
    logic                  r_dp, w_dp_next;
    logic [N_DIGITS-1:0]   r_sel_n, w_sel_n_next;
    logic                  r_frame_done, w_frame_done_next;

    scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk          (clk),
        .rst          (rst),
        .blank_end    (w_blank_end),
        .pre_slot_end (w_pre_slot_end),
        .slot_end     (w_slot_end)
    );

    // Slot phase and digit index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Phase sequencing: BLANK -> SETUP -> SHOW -> BLANK of the next digit
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_BLANK: if (w_blank_end) w_state_next = ST_SETUP;
            ST_SETUP: w_state_next = ST_SHOW;
            ST_SHOW: begin
                if (w_slot_end) begin
                    w_state_next = ST_BLANK;
                    w_idx_next   = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
                end
            end
            default: w_state_next = ST_BLANK;
        endcase
    end

    // Last cycle of the last digit's slot is the frame boundary
    assign w_wrap = (r_state == ST_SHOW) && w_slot_end && (r_idx == c_LAST_IDX);

    // Pending buffer collects loads; shadow only moves at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_val   <= {N_DIGITS{c_BLANK_NIBBLE}};
            r_shadow_dp    <= '0;
            r_shadow_blank <= '0;
            r_pend_val     <= '0;
            r_pend_dp      <= '0;
            r_pend_blank   <= '0;
            r_pending      <= 1'b0;
        end else if (w_wrap) begin
            r_pending <= 1'b0;
            if (load) begin
                r_shadow_val   <= value_in;
                r_shadow_dp    <= dp_in;
                r_shadow_blank <= blank_in;
            end else if (r_pending) begin
                r_shadow_val   <= r_pend_val;
                r_shadow_dp    <= r_pend_dp;
                r_shadow_blank <= r_pend_blank;
            end
        end else if (load) begin
            r_pend_val   <= value_in;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_in;
            r_pending    <= 1'b1;
        end
    end

    // Leading-zero flags: digit k is suppressed when digits N-1..k are all zero
    always_comb begin : lz_scan
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_lz         = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            v_upper_zero = v_upper_zero & (r_shadow_val[4*k +: 4] == 4'h0);
            w_lz[k]      = (LZ_SUPPRESS != 0) && v_upper_zero;
        end
    end

    assign w_dark = r_shadow_blank | w_lz;

    // Next output values derived from the next phase so the registered
    // outputs line up with the phase they belong to
    always_comb begin
        w_sel_n_next      = {N_DIGITS{c_ANODE_OFF}};
        w_nibble_next     = c_BLANK_NIBBLE;
        w_dp_next         = c_DP_OFF;
        w_frame_done_next = w_pre_slot_end && (r_idx == c_LAST_IDX);
        if ((w_state_next != ST_BLANK) && !w_dark[w_idx_next]) begin
            w_nibble_next = r_shadow_val[int'(w_idx_next)*4 +: 4];
            w_dp_next     = ~r_shadow_dp[w_idx_next];
        end
        if (w_state_next == ST_SHOW) begin
            w_sel_n_next[w_idx_next] = ~c_ANODE_OFF;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_n      <= {N_DIGITS{c_ANODE_OFF}};
            r_nibble     <= c_BLANK_NIBBLE;
            r_dp         <= c_DP_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_sel_n      <= w_sel_n_next;
            r_nibble     <= w_nibble_next;
            r_dp         <= w_dp_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign digit_sel_n = r_sel_n;
    assign nibble_out  = r_nibble;
    assign dp_out      = r_dp;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scan_ctrl
//  Purpose  : Self-checking bench for display_scan_ctrl. Two instances (no
//             leading-zero suppression / with suppression) share stimulus and
//             are compared every cycle against a frame/slot arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * R;
    localparam logic [9:0] RST_OBS = {4'b1111, 4'hF, 1'b1, 1'b0};

    logic        clk, rst, load;
    logic [15:0] value_in;
    logic [3:0]  dp_in, blank_in;
    logic [3:0]  nib0, sel0, nib1, sel1;
    logic        dp0, fd0, dp1, fd1;
    logic [9:0]  obs0, obs1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_t = 0;
    logic [15:0] m_sv = 16'hFFFF, m_pv = 16'h0;
    logic [3:0]  m_sdp = 4'h0, m_sbl = 4'h0, m_pdp = 4'h0, m_pbl = 4'h0;
    bit          m_pend = 1'b0;

    display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_SUPPRESS(0)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .dp_in(dp_in),
        .blank_in(blank_in), .nibble_out(nib0), .dp_out(dp0), .digit_sel_n(sel0),
        .frame_done(fd0));

    display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_SUPPRESS(1)) dut_lz (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .dp_in(dp_in),
        .blank_in(blank_in), .nibble_out(nib1), .dp_out(dp1), .digit_sel_n(sel1),
        .frame_done(fd1));

    assign obs0 = {sel0, nib0, dp0, fd0};
    assign obs1 = {sel1, nib1, dp1, fd1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // One clock: update the model with the inputs sampled at this edge
    task automatic step();
        bit wrap;
        @(posedge clk);
        if (rst) begin
            m_t = 0; m_sv = 16'hFFFF; m_sdp = 4'h0; m_sbl = 4'h0; m_pend = 1'b0;
        end else begin
            wrap = ((m_t % FRAME) == FRAME - 1);
            if (load && wrap) begin
                m_sv = value_in; m_sdp = dp_in; m_sbl = blank_in; m_pend = 1'b0;
            end else if (load) begin
                m_pv = value_in; m_pdp = dp_in; m_pbl = blank_in; m_pend = 1'b1;
            end else if (wrap && m_pend) begin
                m_sv = m_pv; m_sdp = m_pdp; m_sbl = m_pbl; m_pend = 1'b0;
            end
            m_t++;
        end
        #1;
    endtask

    function automatic int pos();
        return m_t % FRAME;
    endfunction

    // Expected {digit_sel_n, nibble_out, dp_out, frame_done} for cycle m_t
    function automatic logic [9:0] exp_obs(input bit lz);
        int d, s;
        bit allz, dark;
        logic [3:0] sel, nib;
        logic dp, fd;
        d = (m_t / R) % N;
        s = m_t % R;
        allz = 1'b1;
        for (int j = N - 1; j >= d; j--) if (m_sv[j*4 +: 4] != 4'h0) allz = 1'b0;
        dark = m_sbl[d] || (lz && d != 0 && allz);
        sel = 4'hF; nib = 4'hF; dp = 1'b1;
        fd = ((m_t % FRAME) == FRAME - 1);
        if (s > B) sel[d] = 1'b0;
        if (s >= B && !dark) begin
            nib = m_sv[d*4 +: 4];
            dp  = ~m_sdp[d];
        end
        return {sel, nib, dp, fd};
    endfunction

    task automatic goto_pos(input int p);
        while (pos() != p) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        value_in = v; dp_in = dp; blank_in = bl; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    function automatic logic [15:0] rnd_val();
        logic [15:0] v;
        for (int k = 0; k < N; k++)
            v[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        repeat (3) begin
            step();
            n_checks += 2;
            if (obs0 !== RST_OBS) begin n_fail++; $display("FAIL reset_state lz=0: got %b, expected %b", obs0, RST_OBS); end
            if (obs1 !== RST_OBS) begin n_fail++; $display("FAIL reset_state lz=1: got %b, expected %b", obs1, RST_OBS); end
        end
        rst = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
            step();
            n_checks += 2;
            if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL first_frame lz=0 t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
            if (obs1 !== exp_obs(1)) begin n_fail++; $display("FAIL first_frame lz=1 t=%0d: got %b, expected %b", m_t, obs1, exp_obs(1)); end
            if (m_t == 2 || m_t == 8) begin
                n_checks++;
                if (sel0 !== 4'b1111) begin n_fail++; $display("FAIL anodes_off t=%0d: got %b, expected 1111", m_t, sel0); end
            end
            if (m_t == 3 || m_t == 7) begin
                n_checks++;
                if (sel0 !== 4'b1110) begin n_fail++; $display("FAIL digit0_on t=%0d: got %b, expected 1110", m_t, sel0); end
            end
            if (m_t == 30) begin
                n_checks++;
                if (fd0 !== 1'b0) begin n_fail++; $display("FAIL frame_done_early t=30: got %b, expected 0", fd0); end
            end
        end
        n_checks++;
        if (fd0 !== 1'b1) begin n_fail++; $display("FAIL frame_done t=%0d: got %b, expected 1", m_t, fd0); end
    endtask

    task automatic test_load_midframe();
        logic [15:0] v;
        int d, s;
        v = 16'h1234;
        goto_pos(10);
        do_load(v, 4'h0, 4'h0);
        while (pos() != 0) begin
            step();
            n_checks++;
            if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL midframe_hold t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
        end
        for (int i = 1; i < FRAME; i++) begin
            step();
            d = pos() / R; s = pos() % R;
            n_checks++;
            if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL midframe_show t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
            if (s == B || s == B + 1) begin
                n_checks++;
                if (nib0 !== v[d*4 +: 4]) begin n_fail++; $display("FAIL setup_nibble d=%0d s=%0d: got %h, expected %h", d, s, nib0, v[d*4 +: 4]); end
            end
            if (s == B) begin
                n_checks++;
                if (sel0 !== 4'hF) begin n_fail++; $display("FAIL setup_anodes d=%0d: got %b, expected 1111", d, sel0); end
            end
        end
    endtask

    task automatic test_double_load();
        logic [15:0] v;
        int d;
        v = 16'h5678;
        goto_pos(5);
        do_load(16'h1111, 4'h0, 4'h0);
        goto_pos(20);
        do_load(v, 4'h0, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            n_checks++;
            if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL double_load t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
            if (i > FRAME && (pos() % R) == B + 1) begin
                d = pos() / R;
                n_checks++;
                if (nib0 !== v[d*4 +: 4]) begin n_fail++; $display("FAIL last_load_wins d=%0d: got %h, expected %h", d, nib0, v[d*4 +: 4]); end
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2];
        logic [15:0] shown [2];
        int d;
        vals[0] = 16'h0070; shown[0] = 16'hFF70;
        vals[1] = 16'h0000; shown[1] = 16'hFFF0;
        for (int k = 0; k < 2; k++) begin
            goto_pos(12);
            do_load(vals[k], 4'h0, 4'h0);
            goto_pos(0);
            for (int i = 1; i < FRAME; i++) begin
                step();
                n_checks += 2;
                if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL lz_frame lz=0 t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
                if (obs1 !== exp_obs(1)) begin n_fail++; $display("FAIL lz_frame lz=1 t=%0d: got %b, expected %b", m_t, obs1, exp_obs(1)); end
                if ((pos() % R) == B + 1) begin
                    d = pos() / R;
                    n_checks += 2;
                    if (nib1 !== shown[k][d*4 +: 4]) begin n_fail++; $display("FAIL lz_digit d=%0d: got %h, expected %h", d, nib1, shown[k][d*4 +: 4]); end
                    if (nib0 !== vals[k][d*4 +: 4]) begin n_fail++; $display("FAIL no_lz_digit d=%0d: got %h, expected %h", d, nib0, vals[k][d*4 +: 4]); end
                end
            end
        end
    endtask

    task automatic test_blank_dp();
        int d;
        goto_pos(12);
        do_load(16'h9876, 4'b0001, 4'b0100);
        goto_pos(0);
        for (int i = 1; i < FRAME; i++) begin
            step();
            d = pos() / R;
            n_checks++;
            if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL blank_dp t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
            if ((pos() % R) > B) begin
                n_checks++;
                if (dp0 !== (d != 0)) begin n_fail++; $display("FAIL dp_digit d=%0d: got %b, expected %b", d, dp0, (d != 0)); end
                if (d == 2) begin
                    n_checks++;
                    if (nib0 !== 4'hF) begin n_fail++; $display("FAIL forced_blank: got %h, expected f", nib0); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_show();
        goto_pos(2 * R + B + 2);
        n_checks++;
        if (sel0 !== 4'b1011) begin n_fail++; $display("FAIL digit2_show: got %b, expected 1011", sel0); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks += 2;
        if (obs0 !== RST_OBS) begin n_fail++; $display("FAIL reset_mid_show lz=0: got %b, expected %b", obs0, RST_OBS); end
        if (obs1 !== RST_OBS) begin n_fail++; $display("FAIL reset_mid_show lz=1: got %b, expected %b", obs1, RST_OBS); end
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL after_reset t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
            if (m_t == B + 1) begin
                n_checks++;
                if ({sel0, nib0} !== {4'b1110, 4'hF}) begin n_fail++; $display("FAIL shadow_cleared: got %b_%h, expected 1110_f", sel0, nib0); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        logic [3:0] want;
        // Load on the wrap cycle goes straight to shadow; a load right after
        // waits for the following frame
        goto_pos(FRAME - 1);
        do_load(16'h4321, 4'h0, 4'h0);
        do_load(16'h8888, 4'h0, 4'h0);
        f0 = m_t / FRAME;
        for (int i = 0; i < 2 * FRAME - 2; i++) begin
            step();
            n_checks++;
            if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL back_to_back t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
            if (pos() == B + 1) begin
                want = (m_t / FRAME == f0) ? 4'h1 : 4'h8;
                n_checks++;
                if (nib0 !== want) begin n_fail++; $display("FAIL wrap_load_direct: got %h, expected %h", nib0, want); end
            end
        end
        // Wrap-cycle load supersedes an earlier pending load, which is dropped
        goto_pos(10);
        do_load(16'h5555, 4'h0, 4'h0);
        goto_pos(FRAME - 1);
        do_load(16'h6666, 4'h0, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (pos() == B + 1) begin
                n_checks++;
                if (nib0 !== 4'h6) begin n_fail++; $display("FAIL pending_dropped: got %h, expected 6", nib0); end
            end
        end
    endtask

    task automatic test_random();
        int rst_at;
        rst_at = $urandom_range(3 * FRAME, 5 * FRAME);
        for (int i = 0; i < 10 * FRAME; i++) begin
            rst      = (i == rst_at);
            load     = !rst && ((pos() == FRAME - 1) ? ($urandom_range(0, 1) == 1)
                                                     : ($urandom_range(0, 9) == 0));
            value_in = rnd_val();
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step();
            n_checks += 2;
            if (obs0 !== exp_obs(0)) begin n_fail++; $display("FAIL random lz=0 t=%0d: got %b, expected %b", m_t, obs0, exp_obs(0)); end
            if (obs1 !== exp_obs(1)) begin n_fail++; $display("FAIL random lz=1 t=%0d: got %b, expected %b", m_t, obs1, exp_obs(1)); end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_double_load();
        test_lz();
        test_blank_dp();
        test_reset_mid_show();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
